pwm_serializer: RTL and testbench

//   Fixed-period PWM generator for the audio output path. Converts a 0..100 duty

---
 rtl/pwm_serializer_pkg.sv | 21 ++
 rtl/pwm_serializer_if.sv | 12 +
 rtl/pwm_serializer_window_counter.sv | 28 ++
 rtl/pwm_serializer.sv | 65 ++++++
 tb/tb_pwm_serializer.sv | 137 +++++++++++++
 5 files changed

// File: rtl/pwm_serializer_pkg.sv
// Shared constants and helpers for the PWM audio serializer: duty clamping and
// the duty-to-threshold conversion used by the comparator.
package pwm_pkg;

    localparam int PWM_DUTY_W   = 7;
    localparam int PWM_DUTY_MAX = 100;

    typedef logic [PWM_DUTY_W-1:0] duty_t;

    function automatic duty_t clamp_duty(input duty_t d);
        return (d > duty_t'(PWM_DUTY_MAX)) ? duty_t'(PWM_DUTY_MAX) : d;
    endfunction

    // 32-bit product leaves room for 7+$clog2(W+1) bits as long as W < 2**25.
    function automatic logic [31:0] threshold(input duty_t d, input logic [31:0] w);
        logic [31:0] prod;
        prod = {25'd0, d} * w;
        return prod / 32'(PWM_DUTY_MAX);
    endfunction

endpackage

// File: rtl/pwm_serializer_if.sv
// Duty request / PWM output bundle between a tone generator (master) and the
// PWM serializer (slave).
interface pwm_serializer_if;
    import pwm_pkg::*;

    logic [PWM_DUTY_W-1:0] duty_cycle;
    logic                  signal;

    modport master (output duty_cycle, input signal);
    modport slave  (input duty_cycle, output signal);

endinterface

// File: rtl/pwm_serializer_window_counter.sv
// Free-running 0..W-1 window counter; wrap is high while cnt==0, marking the
// first cycle of each PWM window.
module pwm_window_counter #(
    parameter  int W     = 100,
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(W - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = (r_cnt == '0);

endmodule

// File: rtl/pwm_serializer.sv
// Fixed-period PWM generator: W = SYS_FREQ/PULSE_FREQ clocks per window, high for
// floor(d*W/100) clocks. Define PWM_SERIALIZER_DUTY_LATCH_EN to hold duty per window.
module pwm_serializer
    import pwm_pkg::*;
#(
    parameter int PULSE_FREQ = 1,
    parameter int SYS_FREQ   = 100
) (
    input  logic             clk,
    input  logic             reset,
    pwm_serializer_if.slave  pwmBus
);

    localparam int W     = SYS_FREQ / PULSE_FREQ;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int THR_W = $clog2(W + 1);

    logic [CNT_W-1:0] w_cnt;
    logic             w_windowStart;
    duty_t            w_dutyLive;
    duty_t            w_dutyEff;
    logic [THR_W-1:0] w_threshold;
    logic [THR_W-1:0] w_cntExt;
    logic             r_signal;

    pwm_window_counter #(.W(W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .cnt   (w_cnt),
        .wrap  (w_windowStart)
    );

    assign w_dutyLive = clamp_duty(pwmBus.duty_cycle);

`ifdef PWM_SERIALIZER_DUTY_LATCH_EN
    duty_t r_dutyLatched;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dutyLatched <= '0;
        end else if (w_windowStart) begin
            r_dutyLatched <= w_dutyLive;
        end
    end

    // The window-start cycle already needs the new value, so bypass the latch there.
    assign w_dutyEff = w_windowStart ? w_dutyLive : r_dutyLatched;
`else
    assign w_dutyEff = w_dutyLive;
`endif

    assign w_threshold = THR_W'(threshold(w_dutyEff, 32'(W)));
    assign w_cntExt    = THR_W'(w_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_signal <= 1'b0;
        end else begin
            r_signal <= (w_cntExt < w_threshold);
        end
    end

    assign pwmBus.signal = r_signal;

endmodule

// File: tb/tb_pwm_serializer.sv
// Directed bench for pwm_serializer: a W=100 instance and a W=25 instance share
// clock and reset; windows are checked sample-by-sample on the falling edge.
module tb_pwm_serializer;

    logic clk = 1'b0;
    logic reset;
    int   vectorCount = 0;
    int   failCount   = 0;

    pwm_serializer_if bus100 ();
    pwm_serializer_if bus25 ();

    pwm_serializer dut100 (
        .clk    (clk),
        .reset  (reset),
        .pwmBus (bus100.slave)
    );

    pwm_serializer #(.PULSE_FREQ(4), .SYS_FREQ(100)) dut25 (
        .clk    (clk),
        .reset  (reset),
        .pwmBus (bus25.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] duty100, input logic [6:0] duty25);
        bus100.duty_cycle = duty100;
        bus25.duty_cycle  = duty25;
    endtask

    function automatic logic sampleSig(input bit sel);
        return sel ? bus25.signal : bus100.signal;
    endfunction

    // Must be entered at a falling edge where the selected counter sits at 0.
    task automatic checkWindows(input bit sel, input int w, input int t,
                                input int nWin, input string tag);
        for (int win = 0; win < nWin; win++) begin
            int   hi;
            int   shapeErr;
            logic s;
            hi       = 0;
            shapeErr = 0;
            for (int i = 0; i < w; i++) begin
                @(negedge clk);
                s = sampleSig(sel);
                if (s === 1'b1) hi++;
                if (s !== logic'(i < t)) shapeErr++;
            end
            checkOutput($sformatf("%s high w%0d", tag, win), hi, t);
            checkOutput($sformatf("%s shape w%0d", tag, win), shapeErr, 0);
        end
    endtask

    initial begin
        int   hi;
        int   shapeErr;
        int   midT;
        logic s;

        reset = 1'b1;
        applyStimulus(7'd25, 7'd50);
        repeat (3) @(negedge clk);
        checkOutput("resetSig100", bus100.signal, 0);
        checkOutput("resetSig25", bus25.signal, 0);
        reset = 1'b0;

        checkWindows(0, 100, 25, 3, "duty25");
        applyStimulus(7'd0, 7'd50);
        checkWindows(0, 100, 0, 2, "duty0");
        applyStimulus(7'd100, 7'd50);
        checkWindows(0, 100, 100, 2, "duty100");
        applyStimulus(7'd127, 7'd50);
        checkWindows(0, 100, 100, 2, "duty127");

`ifdef PWM_SERIALIZER_DUTY_LATCH_EN
        midT = 25;
`else
        midT = 75;
`endif
        applyStimulus(7'd25, 7'd50);
        hi       = 0;
        shapeErr = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) bus100.duty_cycle = 7'd75;
            @(negedge clk);
            s = bus100.signal;
            if (s === 1'b1) hi++;
            if (s !== logic'((i < 10) ? (i < 25) : (i < midT))) shapeErr++;
        end
        checkOutput("midChange high", hi, midT);
        checkOutput("midChange shape", shapeErr, 0);
        checkWindows(0, 100, 75, 1, "afterChange");

        applyStimulus(7'd60, 7'd50);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus100.signal === 1'b1) hi++;
        end
        checkOutput("preReset high", hi, 50);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetSig", bus100.signal, 0);
        reset = 1'b0;
        checkWindows(0, 100, 60, 1, "postReset");

        checkWindows(1, 25, 12, 2, "w25duty50");
        applyStimulus(7'd60, 7'd100);
        checkWindows(1, 25, 25, 2, "w25duty100");

        for (int seg = 0; seg < 4; seg++) begin
            applyStimulus((seg % 2 == 0) ? 7'd75 : 7'd25, 7'd50);
            hi = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (bus100.signal === 1'b1) hi++;
            end
            checkOutput($sformatf("alternate seg%0d", seg), hi,
                        (seg % 2 == 0) ? 300 : 100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
